snow_hcompose_row_sched: RTL and testbench

Row scheduler for the ff_snow_horizontal_compose97i kernel. It accepts one frame-level command (base pointer, temp pointer, width, height, row stride). It then calls the kernel once per row, in strict order, using the kernel's call and return handshakes. Only one call is in flight at a time, because all rows share the temp buffer. The block sits between the frame-level IDWT sequencer and the kernel instance.

---
 rtl/snow_hcompose_row_sched.sv | 125 ++++++++++++
 tb/tb_snow_hcompose_row_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snow_hcompose_row_sched.sv
// Row scheduler for the horizontal 9/7 compose kernel: walks one frame command
// row by row, keeping a single kernel call in flight because rows share temp.
module snow_hcompose_row_sched #(
   parameter int unsigned ELEM_BYTES  = 2,
   parameter int unsigned TIMEOUT_CYC = 1048576
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        go,
   input  logic [63:0] b_base,
   input  logic [63:0] temp_in,
   input  logic [31:0] width_in,
   input  logic [31:0] height_in,
   input  logic [31:0] stride_in,
   output logic        sched_busy,
   output logic        sched_done,
   output logic        err,
   output logic [31:0] row_idx,
   output logic        k_start,
   input  logic        k_busy,
   output logic [63:0] k_b,
   output logic [63:0] k_temp,
   output logic [31:0] k_width,
   input  logic        k_done,
   output logic        k_stall
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYC);
   localparam logic [63:0] ELEM_W    = 64'(ELEM_BYTES);

   state_t      state, state_next;
   logic [63:0] cur_addr;
   logic [63:0] temp_r;
   logic [63:0] inc_r;
   logic [31:0] width_r;
   logic [31:0] height_r;
   logic [31:0] row_r;
   logic [31:0] wdog;
   logic        err_r;
   logic        last_row;
   logic        timeout_hit;

   assign last_row    = (row_r == height_r - 32'd1);
   assign timeout_hit = (TIMEOUT_W != 32'd0) && (wdog + 32'd1 == TIMEOUT_W);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // A kernel return in the same cycle as watchdog expiry takes priority.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (go) state_next = (height_in == 32'd0 || width_in == 32'd0) ? FINISH : ISSUE;
         ISSUE:  if (!k_busy) state_next = WAIT;
         WAIT: begin
            if (k_done)           state_next = last_row ? FINISH : ISSUE;
            else if (timeout_hit) state_next = FINISH;
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cur_addr <= '0;
         temp_r   <= '0;
         inc_r    <= '0;
         width_r  <= '0;
         height_r <= '0;
         row_r    <= '0;
         wdog     <= '0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  cur_addr <= b_base;
                  temp_r   <= temp_in;
                  width_r  <= width_in;
                  height_r <= height_in;
                  inc_r    <= {32'd0, stride_in} * ELEM_W;
                  row_r    <= '0;
                  wdog     <= '0;
                  err_r    <= 1'b0;
               end else if (k_done) begin
                  err_r <= 1'b1;
               end
            end
            ISSUE: begin
               if (k_done)  err_r <= 1'b1;
               if (!k_busy) wdog  <= '0;
            end
            WAIT: begin
               wdog <= wdog + 32'd1;
               if (k_done) begin
                  if (!last_row) begin
                     row_r    <= row_r + 32'd1;
                     cur_addr <= cur_addr + inc_r;
                  end
               end else if (timeout_hit) begin
                  err_r <= 1'b1;
               end
            end
            FINISH: if (k_done) err_r <= 1'b1;
            default: ;
         endcase
      end
   end

   assign sched_busy = (state != IDLE);
   assign sched_done = (state == FINISH);
   assign k_start    = (state == ISSUE);
   assign k_stall    = (state != WAIT);
   assign k_b        = k_start ? cur_addr : 64'd0;
   assign k_temp     = k_start ? temp_r   : 64'd0;
   assign k_width    = k_start ? width_r  : 32'd0;
   assign row_idx    = row_r;
   assign err        = err_r;

endmodule

// File: tb/tb_snow_hcompose_row_sched.sv
// Scoreboard bench: stimulus pushes expected kernel calls and completions,
// a monitor pops and compares them as the scheduler produces them.
module tb_snow_hcompose_row_sched;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        go = 1'b0;
   logic [63:0] b_base = '0;
   logic [63:0] temp_in = '0;
   logic [31:0] width_in = '0;
   logic [31:0] height_in = '0;
   logic [31:0] stride_in = '0;
   logic        sched_busy, sched_done, err, k_start, k_stall;
   logic [31:0] row_idx, k_width;
   logic [63:0] k_b, k_temp;
   logic        k_busy = 1'b0;
   logic        k_done = 1'b0;

   typedef struct {
      bit          is_done;
      logic [63:0] b;
      logic [63:0] temp;
      logic [31:0] width;
      logic [31:0] row;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   klat = 5;
   int   kbusy_cfg = 0;
   bit   knever = 1'b0;
   bit   spur_issue = 1'b0;
   bit   spur_now = 1'b0;

   snow_hcompose_row_sched #(.ELEM_BYTES(2), .TIMEOUT_CYC(16)) dut (
      .clock(clock), .resetn(resetn), .go(go), .b_base(b_base), .temp_in(temp_in),
      .width_in(width_in), .height_in(height_in), .stride_in(stride_in),
      .sched_busy(sched_busy), .sched_done(sched_done), .err(err), .row_idx(row_idx),
      .k_start(k_start), .k_busy(k_busy), .k_b(k_b), .k_temp(k_temp), .k_width(k_width),
      .k_done(k_done), .k_stall(k_stall)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: row r is called at b + r*stride*2 (mod 2^64), then one completion.
   task automatic applyStimulus(input logic [63:0] b, input logic [63:0] t, input logic [31:0] w,
                                input logic [31:0] h, input logic [31:0] s,
                                input logic err_exp, input bit only_first);
      exp_t e;
      int unsigned rows;
      rows = (h == 0 || w == 0) ? 0 : (only_first ? 1 : h);
      for (int unsigned r = 0; r < rows; r++) begin
         e = '{1'b0, b + 64'(r) * (64'(s) * 64'd2), t, w, 32'(r), 1'b0};
         exp_q.push_back(e);
      end
      e = '{1'b1, 64'd0, 64'd0, 32'd0, 32'd0, err_exp};
      exp_q.push_back(e);
      b_base = b; temp_in = t; width_in = w; height_in = h; stride_in = s;
      go = 1'b1;
      @(posedge clock); #1;
      go = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!sched_done && n < budget);
      checkOutput(name, {63'd0, sched_done}, 64'd1);
      @(posedge clock); #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"}, {63'd0, sched_busy}, 64'd0);
      checkOutput({tag, "_done"}, {63'd0, sched_done}, 64'd0);
      checkOutput({tag, "_err"}, {63'd0, err}, 64'd0);
      checkOutput({tag, "_row"}, {32'd0, row_idx}, 64'd0);
      checkOutput({tag, "_kstart"}, {63'd0, k_start}, 64'd0);
      checkOutput({tag, "_kb"}, k_b, 64'd0);
      checkOutput({tag, "_ktemp"}, k_temp, 64'd0);
      checkOutput({tag, "_kwidth"}, {32'd0, k_width}, 64'd0);
      checkOutput({tag, "_kstall"}, {63'd0, k_stall}, 64'd1);
   endtask

   // Kernel model: stalls the first kbusy_cfg ISSUE cycles, returns klat cycles after acceptance.
   initial begin : kernel
      int wait_cnt, issue_cnt;
      bit in_call, acc;
      wait_cnt = 0; issue_cnt = 0; in_call = 0;
      forever begin
         @(negedge clock);
         acc = resetn && k_start && !k_busy;
         @(posedge clock); #1;
         k_done = 1'b0;
         if (!resetn) begin
            in_call = 0; issue_cnt = 0; k_busy = 1'b0;
         end else begin
            if (acc && !knever) begin in_call = 1; wait_cnt = klat; end
            if (in_call) begin
               if (wait_cnt <= 1) begin k_done = 1'b1; in_call = 0; end
               else wait_cnt--;
            end
            if (k_start) begin
               issue_cnt++;
               k_busy = (issue_cnt <= kbusy_cfg);
               if (spur_issue) begin k_done = 1'b1; spur_issue = 0; end
            end else begin
               issue_cnt = 0;
               k_busy = 1'b0;
            end
            if (spur_now) begin k_done = 1'b1; spur_now = 0; end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (resetn) begin
            if (k_start && k_busy && exp_q.size() > 0 && !exp_q[0].is_done)
               checkOutput("stall_k_b", k_b, exp_q[0].b);
            if (k_start && !k_busy) begin
               if (exp_q.size() == 0 || exp_q[0].is_done) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_call: k_b=0x%0h row=%0d, no call expected", k_b, row_idx);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("call_k_b", k_b, e.b);
                  checkOutput("call_k_temp", k_temp, e.temp);
                  checkOutput("call_k_width", {32'd0, k_width}, {32'd0, e.width});
                  checkOutput("call_row_idx", {32'd0, row_idx}, {32'd0, e.row});
               end
            end
            if (sched_done) begin
               if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_done: %0d entries pending", exp_q.size());
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("done_err", {63'd0, err}, {63'd0, e.err});
               end
            end
         end
      end
   end

   initial begin : watchdog_guard
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] aborted");
   end

   initial begin : stimulus
      int n;
      logic [31:0] h;
      repeat (3) @(posedge clock);
      #1;
      checkResetValues("reset");
      resetn = 1'b1;
      @(posedge clock); #1;

      klat = 5;
      applyStimulus(64'h1000, 64'h2000_0000, 32, 3, 64, 1'b0, 0);
      waitDone("nominal_done", 80);
      checkOutput("nominal_err", {63'd0, err}, 64'd0);

      applyStimulus(64'h4000, 64'h5000, 16, 0, 8, 1'b0, 0);
      @(negedge clock);
      checkOutput("zero_h_done", {63'd0, sched_done}, 64'd1);
      @(posedge clock); #1;
      applyStimulus(64'h4000, 64'h5000, 0, 5, 8, 1'b0, 0);
      @(negedge clock);
      checkOutput("zero_w_done", {63'd0, sched_done}, 64'd1);
      @(posedge clock); #1;

      kbusy_cfg = 4; klat = 3;
      applyStimulus(64'hABCD_0000, 64'h77, 100, 2, 1000, 1'b0, 0);
      waitDone("stall_done", 80);
      kbusy_cfg = 0;

      klat = 16;
      applyStimulus(64'h9000, 64'h88, 8, 1, 4, 1'b0, 0);
      waitDone("race_done", 60);
      klat = 15;
      applyStimulus(64'h9100, 64'h88, 8, 1, 4, 1'b0, 0);
      waitDone("lat15_done", 60);

      knever = 1'b1;
      applyStimulus(64'h6000, 64'h99, 32, 3, 16, 1'b1, 1);
      n = 0;
      do begin @(negedge clock); n++; end while (!(k_start && !k_busy) && n < 20);
      checkOutput("wd_accept", {63'd0, k_start && !k_busy}, 64'd1);
      n = 0;
      do begin @(negedge clock); n++; end while (!sched_done && n < 40);
      checkOutput("wd_latency", 64'(n), 64'd17);
      @(posedge clock); #1;
      knever = 1'b0;
      spur_now = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("err_sticky", {63'd0, err}, 64'd1);
      klat = 2;
      applyStimulus(64'h7000, 64'h99, 32, 1, 16, 1'b0, 0);
      checkOutput("err_cleared", {63'd0, err}, 64'd0);
      waitDone("after_wd_done", 40);

      klat = 4; spur_issue = 1'b1;
      applyStimulus(64'h8000, 64'h1234, 64, 4, 32, 1'b1, 0);
      @(posedge clock); #1;
      b_base = 64'hDEAD_0000; go = 1'b1;
      @(posedge clock); #1;
      go = 1'b0;
      checkOutput("busy_during_cmd", {63'd0, sched_busy}, 64'd1);
      waitDone("busy_spur_done", 120);

      klat = 8;
      applyStimulus(64'hC000, 64'h4444, 20, 4, 100, 1'b0, 0);
      n = 0;
      do begin @(negedge clock); n++; end
      while (!(row_idx == 32'd2 && sched_busy && !k_start) && n < 200);
      checkOutput("rst_reach_row2", {32'd0, row_idx}, 64'd2);
      #2 resetn = 1'b0;
      #1;
      checkResetValues("midrst");
      exp_q.delete();
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      applyStimulus(64'hC000, 64'h4444, 20, 2, 100, 1'b0, 0);
      waitDone("restart_done", 80);

      for (int i = 0; i < 8; i++) begin
         klat = $urandom_range(1, 12);
         kbusy_cfg = $urandom_range(0, 3);
         h = $urandom_range(1, 4);
         applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, $urandom, h, $urandom, 1'b0, 0);
         waitDone("rand_done", 200);
      end

      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
